// File: rtl/seg7_to_tc4_decoder_if.sv
// Segment-bus input and valid/ready value output of seg7_to_tc4_decoder.
// master = bus driver / consumer side, slave = decoder side.
interface seg7_to_tc4_decoder_if;
  logic [6:0] seg_in;
  logic       seg_valid;
  logic       seg_sel;
  logic [3:0] N;
  logic       out_valid;
  logic       out_ready;
  logic       err;
  logic       overrun;
  logic [7:0] err_count;

  modport master (
    output seg_in, seg_valid, seg_sel, out_ready,
    input  N, out_valid, err, overrun, err_count
  );

  modport slave (
    input  seg_in, seg_valid, seg_sel, out_ready,
    output N, out_valid, err, overrun, err_count
  );
endinterface

// File: rtl/seg7_to_tc4_decoder.sv
// Decodes multiplexed active-low sign/magnitude 7-segment frames into a filtered 4-bit
// two's-complement value. Optional saturating error counter: SEG7_TC4_ERRCNT_EN.
//
// state     | meaning
// WAIT_SIGN | expecting a sign digit; a magnitude digit here is a framing error
// WAIT_MAG  | sign stored; a magnitude digit completes the frame, a sign digit replaces it
module seg7_to_tc4_decoder #(
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  seg7_to_tc4_decoder_if.slave  bus
);

  localparam logic [0:0] WAIT_SIGN = 1'b0;
  localparam logic [0:0] WAIT_MAG  = 1'b1;
  localparam logic [3:0] STABLE    = 4'(STABLE_CNT);

  logic [0:0] state_q;
  logic       sign_ok_q, sign_neg_q;
  logic       cand_vld_q;
  logic [3:0] cand_q, cnt_q;
  logic       last_vld_q;
  logic [3:0] last_q;
  logic [3:0] n_q;
  logic       out_valid_q, err_q, overrun_q;

  logic       mag_ok;
  logic [3:0] mag_d;
  logic       frame_done, framing_err, frame_legal, cand_hit, emit, err_d;
  logic [3:0] frame_val, cnt_next;

  always_comb begin
    mag_ok = 1'b1;
    mag_d  = 4'd0;
    case (bus.seg_in)
      7'b1000000: mag_d = 4'd0;
      7'b1111001: mag_d = 4'd1;
      7'b0100100: mag_d = 4'd2;
      7'b0110000: mag_d = 4'd3;
      7'b0011001: mag_d = 4'd4;
      7'b0010010: mag_d = 4'd5;
      7'b0000010: mag_d = 4'd6;
      7'b1111000: mag_d = 4'd7;
      7'b0000000: mag_d = 4'd8;
      default:    mag_ok = 1'b0;
    endcase
  end

  assign frame_done  = bus.seg_valid & bus.seg_sel & (state_q == WAIT_MAG);
  assign framing_err = bus.seg_valid & bus.seg_sel & (state_q == WAIT_SIGN);
  // -0 and +8 have no 4-bit two's-complement meaning
  assign frame_legal = sign_ok_q & mag_ok
                     & ~(sign_neg_q & (mag_d == 4'd0))
                     & ~(~sign_neg_q & (mag_d == 4'd8));
  assign frame_val   = sign_neg_q ? (4'd0 - mag_d) : mag_d;
  assign cand_hit    = cand_vld_q & (cand_q == frame_val);
  assign cnt_next    = cand_hit ? ((cnt_q >= STABLE) ? cnt_q : cnt_q + 4'd1) : 4'd1;
  assign emit        = frame_done & frame_legal & (cnt_next == STABLE)
                     & (~last_vld_q | (last_q != frame_val));
  assign err_d       = framing_err | (frame_done & ~frame_legal);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= WAIT_SIGN;
      sign_ok_q  <= 1'b0;
      sign_neg_q <= 1'b0;
    end else if (bus.seg_valid) begin
      if (!bus.seg_sel) begin
        sign_ok_q  <= (bus.seg_in == 7'b1111111) | (bus.seg_in == 7'b0111111);
        sign_neg_q <= (bus.seg_in == 7'b0111111);
        state_q    <= WAIT_MAG;
      end else begin
        state_q    <= WAIT_SIGN;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_vld_q <= 1'b0;
      cand_q     <= 4'd0;
      cnt_q      <= 4'd0;
    end else if (frame_done) begin
      if (!frame_legal) begin
        cand_vld_q <= 1'b0;
        cand_q     <= 4'd0;
        cnt_q      <= 4'd0;
      end else begin
        cand_vld_q <= 1'b1;
        cand_q     <= frame_val;
        cnt_q      <= cnt_next;
      end
    end
  end

  // A dropped value leaves last_q untouched so it re-qualifies on a later frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q         <= 4'd0;
      out_valid_q <= 1'b0;
      last_vld_q  <= 1'b0;
      last_q      <= 4'd0;
      err_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      err_q     <= err_d;
      overrun_q <= 1'b0;
      if (emit) begin
        if (!out_valid_q || bus.out_ready) begin
          n_q         <= frame_val;
          out_valid_q <= 1'b1;
          last_vld_q  <= 1'b1;
          last_q      <= frame_val;
        end else begin
          overrun_q   <= 1'b1;
        end
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef SEG7_TC4_ERRCNT_EN
  logic [7:0] err_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count_q <= 8'h00;
    end else if (err_d && (err_count_q != 8'hFF)) begin
      err_count_q <= err_count_q + 8'h01;
    end
  end

  assign bus.err_count = err_count_q;
`else
  assign bus.err_count = 8'h00;
`endif

  assign bus.N         = n_q;
  assign bus.out_valid = out_valid_q;
  assign bus.err       = err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_seg7_to_tc4_decoder.sv
// Scoreboard bench for seg7_to_tc4_decoder: driver pushes reference-model expectations
// tagged with their target edge; a negedge monitor pops and compares them.
module tb_seg7_to_tc4_decoder;
  localparam int STABLE = 3;
  localparam logic [6:0] POS = 7'b1111111;
  localparam logic [6:0] NEG = 7'b0111111;
  localparam logic [6:0] MAG [0:8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                       7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                       7'b0000000};

  logic clk = 1'b0;
  logic reset;
  seg7_to_tc4_decoder_if bus();

  seg7_to_tc4_decoder #(.STABLE_CNT(STABLE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned tgt;
    logic [3:0]  n;
    logic        vld;
    logic        err;
    logic        ovr;
    logic [7:0]  ecnt;
  } exp_t;
  exp_t sb[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // reference model: frames as signed integers, stability as an unbounded run length
  bit         m_have_sign;
  logic [6:0] m_sign;
  int         m_run_val, m_run_len;
  bit         m_last_set;
  int         m_last;
  bit         m_vld;
  logic [3:0] m_n;
  int         m_ecnt;

  function automatic int mag_of(logic [6:0] w);
    for (int i = 0; i <= 8; i++) if (MAG[i] == w) return i;
    return -1;
  endfunction

  function automatic void model_reset();
    m_have_sign = 0; m_sign = '0; m_run_val = 0; m_run_len = 0;
    m_last_set = 0; m_last = 0; m_vld = 0; m_n = '0; m_ecnt = 0;
  endfunction

  function automatic void model_step(bit v, bit sel, logic [6:0] w, bit rdy,
                                     output bit e, output bit o);
    bit emit_now = 0;
    int val = 0;
    e = 0; o = 0;
    if (v && !sel) begin
      m_sign = w; m_have_sign = 1;
    end else if (v && sel) begin
      if (!m_have_sign) e = 1;
      else begin
        int d = mag_of(w);
        bit legal = 0;
        m_have_sign = 0;
        if (d >= 0 && m_sign == POS && d <= 7) begin legal = 1; val = d; end
        if (d >= 1 && m_sign == NEG) begin legal = 1; val = -d; end
        if (legal) begin
          if (m_run_len > 0 && val == m_run_val) m_run_len++;
          else begin m_run_val = val; m_run_len = 1; end
          emit_now = (m_run_len >= STABLE) && (!m_last_set || val != m_last);
        end else begin
          e = 1; m_run_len = 0;
        end
      end
    end
    if (emit_now) begin
      if (!m_vld || rdy) begin
        m_n = 4'((val + 16) % 16); m_vld = 1; m_last = val; m_last_set = 1;
      end else o = 1;
    end else if (m_vld && rdy) m_vld = 0;
`ifdef SEG7_TC4_ERRCNT_EN
    if (e && m_ecnt < 255) m_ecnt++;
`endif
  endfunction

  task automatic step(bit v, bit sel, logic [6:0] w, bit rdy);
    exp_t x;
    bit e, o;
    bus.seg_valid = v; bus.seg_sel = sel; bus.seg_in = w; bus.out_ready = rdy;
    if (reset) begin model_reset(); e = 0; o = 0; end
    else model_step(v, sel, w, rdy, e, o);
    x.tgt = cyc + 1; x.n = m_n; x.vld = m_vld; x.err = e; x.ovr = o; x.ecnt = 8'(m_ecnt);
    sb.push_back(x);
    @(posedge clk); #1;
  endtask

  task automatic frame(logic [6:0] s, logic [6:0] m, bit rdy);
    step(1, 0, s, rdy);
    step(1, 1, m, rdy);
  endtask

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].tgt <= cyc) begin
        x = sb.pop_front();
        chk("sb_align", x.tgt, cyc);
        chk("N", bus.N, x.n);
        chk("out_valid", bus.out_valid, x.vld);
        chk("err", bus.err, x.err);
        chk("overrun", bus.overrun, x.ovr);
        chk("err_count", bus.err_count, x.ecnt);
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.seg_in = '0; bus.seg_valid = 0; bus.seg_sel = 0; bus.out_ready = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_N", bus.N, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_errcnt", bus.err_count, 0);
    reset = 1'b0;

    repeat (20) step(0, 0, 7'h00, 0);

    // -3 stable three times, emitted once
    repeat (3) frame(NEG, MAG[3], 1);
    chk("neg3_valid", bus.out_valid, 1);
    chk("neg3_N", bus.N, 4'b1101);
    frame(NEG, MAG[3], 1);
    chk("neg3_once", bus.out_valid, 0);

    frame(NEG, MAG[0], 1);
    chk("err_neg0", bus.err, 1);
    frame(POS, MAG[8], 1);
    chk("err_pos8", bus.err, 1);
    step(1, 1, MAG[3], 1);
    chk("err_framing", bus.err, 1);
`ifdef SEG7_TC4_ERRCNT_EN
    chk("errcnt3", bus.err_count, 3);
`else
    chk("errcnt3", bus.err_count, 0);
`endif

    // backpressure
    repeat (3) frame(POS, MAG[7], 0);
    chk("bp_N7", bus.N, 4'b0111);
    repeat (3) frame(NEG, MAG[8], 0);
    chk("bp_overrun", bus.overrun, 1);
    chk("bp_N_kept", bus.N, 4'b0111);
    step(0, 0, 7'h00, 1);
    chk("bp_accept", bus.out_valid, 0);
    frame(NEG, MAG[8], 0);
    chk("bp_N8", bus.N, 4'b1000);
    step(0, 0, 7'h00, 1);

    // sign restart, then reset while held
    repeat (3) begin
      step(1, 0, POS, 0);
      step(1, 0, NEG, 0);
      step(1, 1, MAG[1], 0);
    end
    chk("restart_N", bus.N, 4'b1111);
    chk("restart_valid", bus.out_valid, 1);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", bus.out_valid, 0);
    chk("async_rst_N", bus.N, 0);
    @(posedge clk); #1;
    model_reset();
    step(0, 0, 7'h00, 0);
    reset = 1'b0;
    step(0, 0, 7'h00, 0);

    // err_count saturation
    repeat (300) frame(POS, 7'b1010101, 1);
`ifdef SEG7_TC4_ERRCNT_EN
    chk("errcnt_sat", bus.err_count, 8'hFF);
`else
    chk("errcnt_tied", bus.err_count, 8'h00);
`endif

    // randomized frames with repeats, glitches, restarts and idle gaps
    for (int it = 0; it < 400; it++) begin
      int v = int'($urandom_range(0, 15)) - 8;
      int reps = int'($urandom_range(1, 5));
      for (int r = 0; r < reps; r++) begin
        logic [6:0] s = (v < 0) ? NEG : POS;
        logic [6:0] m = MAG[(v < 0) ? -v : v];
        int k = int'($urandom_range(0, 19));
        if (k == 0) s = 7'($urandom);
        if (k == 1) m = 7'($urandom);
        if (k == 2) step(1, 1, MAG[$urandom_range(0, 8)], $urandom_range(0, 3) != 0);
        if (k == 3) step(1, 0, 7'($urandom), $urandom_range(0, 3) != 0);
        step(1, 0, s, $urandom_range(0, 3) != 0);
        if (k == 4) step(0, 1, 7'($urandom), $urandom_range(0, 3) != 0);
        step(1, 1, m, $urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) == 0) step(0, 0, 7'($urandom), $urandom_range(0, 1) != 0);
      end
    end

    repeat (3) step(0, 0, 7'h00, 1);
    @(negedge clk); #1;
    chk("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
